i2c_responder: RTL and testbench

I2C_RESPONDER -- requirements
Module: i2c_responder

---
 rtl/i2c_defs.sv | 21 ++
 rtl/i2c_sync_edge.sv | 32 +++
 rtl/i2c_responder.sv | 171 +++++++++++++++++
 tb/tb_i2c_responder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_defs.sv
// Shared I2C responder definitions: FSM encoding, default bus address, payload size.
package i2c_defs;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_DATA,
        ST_DATA_ACK,
        ST_WAIT_STOP
    } state_t;

    localparam logic [6:0] DEFAULT_DEVICE_ADDR = 7'h1A;
    localparam int         BYTE_COUNT          = 2;

    // True when an address byte is a write aimed at the given device address
    function automatic logic is_write_to(input logic [7:0] addr_byte, input logic [6:0] dev);
        return (addr_byte[7:1] == dev) && !addr_byte[0];
    endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer with rise/fall detection on the synchronized level.
module i2c_sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    // Idle bus level is high, so reset to 1 to avoid a false edge
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~prev;
    assign fall  = ~sync & prev;

endmodule

// File: rtl/i2c_responder.sv
// Write-only I2C responder: accepts exactly two data bytes per transaction.
module i2c_responder
    import i2c_defs::*;
#(
    parameter logic [6:0] DEVICE_ADDR = DEFAULT_DEVICE_ADDR
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i2c_sclk,
    inout  wire         i2c_sdat,
    output logic [15:0] data_out,
    output logic        valid,
    output logic        busy,
    output logic        error
);

    logic scl_level, scl_rise, scl_fall;
    logic sda_level, sda_rise, sda_fall;

    i2c_sync_edge u_scl_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .din    (i2c_sclk),
        .level  (scl_level),
        .rise   (scl_rise),
        .fall   (scl_fall)
    );

    i2c_sync_edge u_sda_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .din    (i2c_sdat),
        .level  (sda_level),
        .rise   (sda_rise),
        .fall   (sda_fall)
    );

    logic start_det, stop_det;
    assign start_det = sda_fall & scl_level;
    assign stop_det  = sda_rise & scl_level;

    state_t      state, state_nx;
    logic [3:0]  bit_cnt, bit_cnt_nx;
    logic [7:0]  shift, shift_nx;
    logic [7:0]  byte1, byte1_nx;
    logic [7:0]  byte2, byte2_nx;
    logic        byte_idx, byte_idx_nx;
    logic        two_done, two_done_nx;
    logic        overrun, overrun_nx;
    logic        addr_ok, addr_ok_nx;
    logic        sda_low, sda_low_nx;
    logic [15:0] data_out_nx;
    logic        valid_nx, error_nx;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            shift    <= '0;
            byte1    <= '0;
            byte2    <= '0;
            byte_idx <= 1'b0;
            two_done <= 1'b0;
            overrun  <= 1'b0;
            addr_ok  <= 1'b0;
            sda_low  <= 1'b0;
            data_out <= '0;
            valid    <= 1'b0;
            error    <= 1'b0;
        end else begin
            state    <= state_nx;
            bit_cnt  <= bit_cnt_nx;
            shift    <= shift_nx;
            byte1    <= byte1_nx;
            byte2    <= byte2_nx;
            byte_idx <= byte_idx_nx;
            two_done <= two_done_nx;
            overrun  <= overrun_nx;
            addr_ok  <= addr_ok_nx;
            sda_low  <= sda_low_nx;
            data_out <= data_out_nx;
            valid    <= valid_nx;
            error    <= error_nx;
        end
    end

    // STOP outranks START; both override whatever the current state is doing
    always_comb begin
        state_nx    = state;
        bit_cnt_nx  = bit_cnt;
        shift_nx    = shift;
        byte1_nx    = byte1;
        byte2_nx    = byte2;
        byte_idx_nx = byte_idx;
        two_done_nx = two_done;
        overrun_nx  = overrun;
        addr_ok_nx  = addr_ok;
        sda_low_nx  = sda_low;
        data_out_nx = data_out;
        valid_nx    = 1'b0;
        error_nx    = 1'b0;

        if (stop_det) begin
            state_nx   = ST_IDLE;
            sda_low_nx = 1'b0;
            if (addr_ok) begin
                if (two_done && !overrun) begin
                    data_out_nx = {byte1, byte2};
                    valid_nx    = 1'b1;
                end else begin
                    error_nx = 1'b1;
                end
            end
            addr_ok_nx  = 1'b0;
            two_done_nx = 1'b0;
            overrun_nx  = 1'b0;
            byte_idx_nx = 1'b0;
            bit_cnt_nx  = '0;
        end else if (start_det) begin
            state_nx    = ST_ADDR;
            sda_low_nx  = 1'b0;
            bit_cnt_nx  = '0;
            shift_nx    = '0;
            addr_ok_nx  = 1'b0;
            two_done_nx = 1'b0;
            overrun_nx  = 1'b0;
            byte_idx_nx = 1'b0;
        end else begin
            case (state)
                ST_ADDR, ST_DATA: begin
                    if (scl_rise && bit_cnt < 4'd8) begin
                        shift_nx   = {shift[6:0], sda_level};
                        bit_cnt_nx = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        if (state == ST_ADDR) begin
                            if (is_write_to(shift, DEVICE_ADDR)) begin
                                addr_ok_nx = 1'b1;
                                sda_low_nx = 1'b1;
                                state_nx   = ST_ADDR_ACK;
                            end else begin
                                state_nx = ST_WAIT_STOP;
                            end
                        end else if (two_done) begin
                            overrun_nx = 1'b1;
                            state_nx   = ST_WAIT_STOP;
                        end else begin
                            if (byte_idx) byte2_nx = shift;
                            else          byte1_nx = shift;
                            if (byte_idx == 1'(BYTE_COUNT - 1)) two_done_nx = 1'b1;
                            byte_idx_nx = ~byte_idx;
                            sda_low_nx  = 1'b1;
                            state_nx    = ST_DATA_ACK;
                        end
                    end
                end
                ST_ADDR_ACK, ST_DATA_ACK: begin
                    if (scl_fall) begin
                        sda_low_nx = 1'b0;
                        bit_cnt_nx = '0;
                        state_nx   = ST_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

    assign i2c_sdat = sda_low ? 1'b0 : 1'bz;
    assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_i2c_responder.sv
// Directed bench for i2c_responder: bit-banged controller with 16-clk bus phases.
module tb_i2c_responder;
    import i2c_defs::*;

    localparam int H = 160;
    localparam int Q = 40;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sclk = 1'b1;
    logic        sda_ctl = 1'b1;
    wire         sdat;
    logic [15:0] data_out;
    logic        valid, busy, error;

    int n_compared = 0;
    int n_mismatched = 0;
    int valid_cnt = 0;
    int error_cnt = 0;
    logic a0, a1, a2, a3;

    pullup (sdat);
    assign sdat = sda_ctl ? 1'bz : 1'b0;

    always #5 clk = ~clk;

    i2c_responder dut (
        .clk     (clk),
        .reset_n (reset_n),
        .i2c_sclk(sclk),
        .i2c_sdat(sdat),
        .data_out(data_out),
        .valid   (valid),
        .busy    (busy),
        .error   (error)
    );

    // Strobe counters: a strobe held two cycles counts twice
    always @(negedge clk) begin
        if (valid) valid_cnt++;
        if (error) error_cnt++;
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        n_compared++;
        assert (observed === expected)
        else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %h required %h", tag, observed, expected);
        end
    endtask

    task automatic bus_start();
        if (sclk == 1'b0) begin
            sda_ctl = 1'b1;
            #(H);
            sclk = 1'b1;
            #(H);
        end
        sda_ctl = 1'b0;
        #(H);
        sclk = 1'b0;
        #(Q);
    endtask

    task automatic bus_stop();
        sda_ctl = 1'b0;
        #(H);
        sclk = 1'b1;
        #(H);
        sda_ctl = 1'b1;
        #(H);
    endtask

    task automatic send_bit(input logic b);
        sda_ctl = b;
        #(H - Q);
        sclk = 1'b1;
        #(H);
        sclk = 1'b0;
        #(Q);
    endtask

    task automatic send_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic ack_slot(output logic a);
        sda_ctl = 1'b1;
        #(H - Q);
        sclk = 1'b1;
        #(H / 2);
        a = sdat;
        #(H / 2);
        sclk = 1'b0;
        #(Q);
    endtask

    task automatic applyStimulus(input logic [7:0] b, output logic a);
        send_bits(b);
        ack_slot(a);
    endtask

    initial begin
        $display("[TB] start");
        repeat (5) @(posedge clk);
        #1;
        checkOutput("rst_data_out", data_out, 16'h0000);
        checkOutput("rst_valid", 16'(valid), 16'h0);
        checkOutput("rst_error", 16'(error), 16'h0);
        checkOutput("rst_busy", 16'(busy), 16'h0);
        checkOutput("rst_sdat", 16'(sdat), 16'h1);
        @(negedge clk);
        reset_n = 1'b1;
        #(H);

        // Good two-byte write
        bus_start();
        applyStimulus(8'h34, a0);
        applyStimulus(8'h1E, a1);
        applyStimulus(8'h00, a2);
        checkOutput("wr_busy", 16'(busy), 16'h1);
        bus_stop();
        checkOutput("wr_ack_addr", 16'(a0), 16'h0);
        checkOutput("wr_ack_b1", 16'(a1), 16'h0);
        checkOutput("wr_ack_b2", 16'(a2), 16'h0);
        checkOutput("wr_valid_cnt", 16'(valid_cnt), 16'd1);
        checkOutput("wr_data_out", data_out, 16'h1E00);
        checkOutput("wr_error_cnt", 16'(error_cnt), 16'd0);
        checkOutput("wr_busy_after", 16'(busy), 16'h0);

        // Wrong address
        bus_start();
        applyStimulus(8'h36, a0);
        checkOutput("na_ack", 16'(a0), 16'h1);
        checkOutput("na_busy", 16'(busy), 16'h1);
        bus_stop();
        checkOutput("na_busy_after", 16'(busy), 16'h0);
        checkOutput("na_valid_cnt", 16'(valid_cnt), 16'd1);
        checkOutput("na_error_cnt", 16'(error_cnt), 16'd0);

        // Read request
        bus_start();
        applyStimulus(8'h35, a0);
        checkOutput("rd_ack", 16'(a0), 16'h1);
        checkOutput("rd_state", 16'(dut.state), 16'(ST_WAIT_STOP));
        bus_stop();
        checkOutput("rd_valid_cnt", 16'(valid_cnt), 16'd1);
        checkOutput("rd_error_cnt", 16'(error_cnt), 16'd0);

        // Only one data byte
        bus_start();
        applyStimulus(8'h34, a0);
        applyStimulus(8'hAB, a1);
        bus_stop();
        checkOutput("one_ack_addr", 16'(a0), 16'h0);
        checkOutput("one_ack_b1", 16'(a1), 16'h0);
        checkOutput("one_error_cnt", 16'(error_cnt), 16'd1);
        checkOutput("one_data_out", data_out, 16'h1E00);
        checkOutput("one_valid_cnt", 16'(valid_cnt), 16'd1);

        // Third byte overruns
        bus_start();
        applyStimulus(8'h34, a0);
        applyStimulus(8'h11, a1);
        applyStimulus(8'h22, a2);
        applyStimulus(8'h33, a3);
        bus_stop();
        checkOutput("ovr_ack_b2", 16'(a2), 16'h0);
        checkOutput("ovr_ack_b3", 16'(a3), 16'h1);
        checkOutput("ovr_error_cnt", 16'(error_cnt), 16'd2);
        checkOutput("ovr_data_out", data_out, 16'h1E00);

        // Repeated START discards the partial transfer
        bus_start();
        applyStimulus(8'h34, a0);
        applyStimulus(8'h12, a1);
        bus_start();
        applyStimulus(8'h34, a0);
        applyStimulus(8'h56, a1);
        applyStimulus(8'h78, a2);
        bus_stop();
        checkOutput("rs_valid_cnt", 16'(valid_cnt), 16'd2);
        checkOutput("rs_data_out", data_out, 16'h5678);
        checkOutput("rs_error_cnt", 16'(error_cnt), 16'd2);

        // Reset while the responder holds ACK low
        bus_start();
        send_bits(8'h34);
        sda_ctl = 1'b1;
        #(H - Q);
        checkOutput("rack_sdat_low", 16'(sdat), 16'h0);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rack_sdat_rel", 16'(sdat), 16'h1);
        checkOutput("rack_busy", 16'(busy), 16'h0);
        #4;
        reset_n = 1'b1;
        #(Q);
        bus_stop();

        // Reset during second data bit of byte 1, then a clean write
        bus_start();
        applyStimulus(8'h34, a0);
        send_bit(1'b1);
        sda_ctl = 1'b1;
        #(H / 2 - Q);
        checkOutput("rbit_busy_before", 16'(busy), 16'h1);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rbit_busy", 16'(busy), 16'h0);
        checkOutput("rbit_sdat", 16'(sdat), 16'h1);
        #4;
        reset_n = 1'b1;
        #(H / 2);
        bus_stop();
        checkOutput("rbit_data_out_cleared", data_out, 16'h0000);
        bus_start();
        applyStimulus(8'h34, a0);
        applyStimulus(8'h00, a1);
        applyStimulus(8'h01, a2);
        bus_stop();
        checkOutput("post_ack_b2", 16'(a2), 16'h0);
        checkOutput("post_data_out", data_out, 16'h0001);
        checkOutput("post_valid_cnt", 16'(valid_cnt), 16'd3);
        checkOutput("post_error_cnt", 16'(error_cnt), 16'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
